// File: rtl/mm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mm_pkg: shared Mastermind datapath types and default widths       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package mm_pkg;

  localparam int DEF_NUM_PEGS = 4;
  localparam int DEF_PEG_W    = 3;
  localparam int DEF_CNT_W    = $clog2(DEF_NUM_PEGS + 1);

  typedef logic [DEF_PEG_W-1:0]    peg_t;
  typedef peg_t [DEF_NUM_PEGS-1:0] guess_t;
  typedef logic [DEF_CNT_W-1:0]    cnt_t;

  typedef struct packed {
    cnt_t black;
    cnt_t white;
  } fb_t;

  typedef struct packed {
    guess_t guess;
    fb_t    fb;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/history_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | history_ram: DEPTH-entry turn store, registered write-first read  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module history_ram
  import mm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = $bits(entry_t)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    // Same-index write and read returns the data being written.
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/guess_history_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | guess_history_buf: committed-guess history with browse control    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module guess_history_buf
  import mm_pkg::*;
#(
  parameter int NUM_PEGS = DEF_NUM_PEGS,
  parameter int PEG_W    = DEF_PEG_W,
  parameter int DEPTH    = 8,
  parameter int TURN_W   = $clog2(DEPTH),
  parameter int CNT_W    = $clog2(NUM_PEGS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      btn_select,
  input  logic [NUM_PEGS*PEG_W-1:0] guess,
  input  logic [CNT_W-1:0]          fb_black,
  input  logic [CNT_W-1:0]          fb_white,
  output logic [NUM_PEGS*PEG_W-1:0] sel_guess,
  output logic [CNT_W-1:0]          sel_black,
  output logic [CNT_W-1:0]          sel_white,
  output logic [TURN_W-1:0]         sel_turn,
  output logic [TURN_W:0]           turn_count,
  output logic                      empty,
  output logic                      full,
  output logic                      store_ack,
  output logic                      overflow
);

  localparam int GW = NUM_PEGS * PEG_W;
  localparam int EW = GW + 2 * CNT_W;

  logic [TURN_W:0]   count_q, count_d;
  logic [TURN_W-1:0] sel_turn_q, sel_turn_d;
  logic              store_ack_q, store_ack_d;
  logic              overflow_q, overflow_d;
  logic [TURN_W-1:0] last_turn;
  logic              is_empty, is_full, do_store;
  logic [EW-1:0]     rd_entry;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == (TURN_W+1)'(DEPTH));
  assign last_turn = is_empty ? '0 : TURN_W'(count_q - 1'b1);
  assign do_store  = !mode && btn_select && !is_full;

  always_comb begin
    count_d     = count_q;
    sel_turn_d  = sel_turn_q;
    store_ack_d = 1'b0;
    overflow_d  = 1'b0;
    if (!mode) begin
      // Guess mode always tracks the newest turn; a store points at the new slot.
      sel_turn_d = last_turn;
      if (btn_select) begin
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          count_d     = count_q + 1'b1;
          sel_turn_d  = TURN_W'(count_q);
          store_ack_d = 1'b1;
        end
      end
    end else if (is_empty) begin
      sel_turn_d = '0;
    end else if (btn_up && !btn_down && (sel_turn_q < last_turn)) begin
      sel_turn_d = sel_turn_q + 1'b1;
    end else if (btn_down && !btn_up && (sel_turn_q != '0)) begin
      sel_turn_d = sel_turn_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      sel_turn_q  <= '0;
      store_ack_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      sel_turn_q  <= sel_turn_d;
      store_ack_q <= store_ack_d;
      overflow_q  <= overflow_d;
    end
  end

  history_ram #(
    .DEPTH (DEPTH),
    .AW    (TURN_W),
    .W     (EW)
  ) u_ram (
    .clk     (clk),
    .we_i    (do_store && !reset),
    .waddr_i (TURN_W'(count_q)),
    .wdata_i ({guess, fb_black, fb_white}),
    .raddr_i (sel_turn_q),
    .rdata_o (rd_entry)
  );

  // Stale read data is hidden whenever nothing is stored.
  assign sel_guess  = is_empty ? '0 : rd_entry[EW-1 -: GW];
  assign sel_black  = is_empty ? '0 : rd_entry[2*CNT_W-1 -: CNT_W];
  assign sel_white  = is_empty ? '0 : rd_entry[CNT_W-1:0];
  assign sel_turn   = sel_turn_q;
  assign turn_count = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign store_ack  = store_ack_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_guess_history_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_guess_history_buf: directed self-checking bench                |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_guess_history_buf;

  logic        clk = 1'b0;
  logic        reset, mode, btn_up, btn_down, btn_select;
  logic [11:0] guess;
  logic [2:0]  fb_black, fb_white;
  logic [11:0] sel_guess;
  logic [2:0]  sel_black, sel_white, sel_turn;
  logic [3:0]  turn_count;
  logic        empty, full, store_ack, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  guess_history_buf #(
    .NUM_PEGS (4),
    .PEG_W    (3),
    .DEPTH    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_select (btn_select),
    .guess      (guess),
    .fb_black   (fb_black),
    .fb_white   (fb_white),
    .sel_guess  (sel_guess),
    .sel_black  (sel_black),
    .sel_white  (sel_white),
    .sel_turn   (sel_turn),
    .turn_count (turn_count),
    .empty      (empty),
    .full       (full),
    .store_ack  (store_ack),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [11:0] g, input logic [2:0] b, input logic [2:0] w,
                          input logic [3:0] exp_cnt);
    guess = g; fb_black = b; fb_white = w; btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
    n_checks++; if (store_ack !== 1'b1) begin n_fail++; $display("FAIL store_ack: got %b want 1", store_ack); end
    n_checks++; if (turn_count !== exp_cnt) begin n_fail++; $display("FAIL store_count: got %0d want %0d", turn_count, exp_cnt); end
    n_checks++; if (sel_turn !== 3'(exp_cnt - 4'd1)) begin n_fail++; $display("FAIL store_sel_turn: got %0d want %0d", sel_turn, exp_cnt - 4'd1); end
    tick();
    n_checks++; if (store_ack !== 1'b0) begin n_fail++; $display("FAIL store_ack_pulse: got %b want 0", store_ack); end
    n_checks++; if ({sel_guess, sel_black, sel_white} !== {g, b, w}) begin n_fail++;
      $display("FAIL store_readback: got %h/%0d/%0d want %h/%0d/%0d", sel_guess, sel_black, sel_white, g, b, w); end
  endtask

  task automatic pulse(input logic up, input logic down, input logic [2:0] exp_turn, input logic [11:0] exp_g);
    btn_up = up; btn_down = down;
    tick();
    btn_up = 1'b0; btn_down = 1'b0;
    n_checks++; if (sel_turn !== exp_turn) begin n_fail++; $display("FAIL browse_turn: got %0d want %0d", sel_turn, exp_turn); end
    tick();
    n_checks++; if (sel_guess !== exp_g) begin n_fail++; $display("FAIL browse_guess: got %h want %h", sel_guess, exp_g); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (turn_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", turn_count); end
    n_checks++; if (sel_turn !== 3'd0) begin n_fail++; $display("FAIL reset_sel_turn: got %0d want 0", sel_turn); end
    n_checks++; if ({sel_guess, sel_black, sel_white} !== 18'd0) begin n_fail++; $display("FAIL reset_sel: got %h want 0", {sel_guess, sel_black, sel_white}); end
    n_checks++; if ({empty, full, store_ack, overflow} !== 4'b1000) begin n_fail++; $display("FAIL reset_flags: got %b want 1000", {empty, full, store_ack, overflow}); end
  endtask

  task automatic test_store();
    do_store(12'h123, 3'd1, 3'd2, 4'd1);
    do_store(12'h456, 3'd0, 3'd0, 4'd2);
    do_store(12'h777, 3'd4, 3'd0, 4'd3);
    n_checks++; if ({empty, full} !== 2'b00) begin n_fail++; $display("FAIL store_flags: got %b want 00", {empty, full}); end
  endtask

  task automatic test_browse();
    mode = 1'b1;
    tick();
    n_checks++; if (sel_turn !== 3'd2) begin n_fail++; $display("FAIL mode_enter_turn: got %0d want 2", sel_turn); end
    pulse(1'b0, 1'b1, 3'd1, 12'h456);
    pulse(1'b0, 1'b1, 3'd0, 12'h123);
    pulse(1'b0, 1'b1, 3'd0, 12'h123);
    pulse(1'b1, 1'b0, 3'd1, 12'h456);
    pulse(1'b1, 1'b0, 3'd2, 12'h777);
    pulse(1'b1, 1'b0, 3'd2, 12'h777);
    pulse(1'b0, 1'b1, 3'd1, 12'h456);
    pulse(1'b1, 1'b1, 3'd1, 12'h456);
    btn_select = 1'b1; guess = 12'hEEE;
    tick();
    btn_select = 1'b0;
    n_checks++; if ({store_ack, turn_count} !== {1'b0, 4'd3}) begin n_fail++; $display("FAIL browse_select_ignored: got %b/%0d want 0/3", store_ack, turn_count); end
    mode = 1'b0;
    tick();
    n_checks++; if (sel_turn !== 3'd2) begin n_fail++; $display("FAIL mode_exit_turn: got %0d want 2", sel_turn); end
    tick();
    n_checks++; if (sel_guess !== 12'h777) begin n_fail++; $display("FAIL mode_exit_guess: got %h want 777", sel_guess); end
  endtask

  task automatic test_full();
    do_store(12'h801, 3'd0, 3'd1, 4'd4);
    do_store(12'h802, 3'd1, 3'd1, 4'd5);
    do_store(12'h803, 3'd2, 3'd0, 4'd6);
    do_store(12'h804, 3'd0, 3'd3, 4'd7);
    do_store(12'hABC, 3'd2, 3'd1, 4'd8);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
    guess = 12'hFFF; fb_black = 3'd4; fb_white = 3'd0; btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
    n_checks++; if ({overflow, store_ack, turn_count} !== {2'b10, 4'd8}) begin n_fail++;
      $display("FAIL overflow: got ovf=%b ack=%b cnt=%0d want 1/0/8", overflow, store_ack, turn_count); end
    tick();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_pulse: got %b want 0", overflow); end
    n_checks++; if ({sel_turn, sel_guess, sel_black, sel_white} !== {3'd7, 12'hABC, 3'd2, 3'd1}) begin n_fail++;
      $display("FAIL entry7_kept: got %0d/%h/%0d/%0d want 7/abc/2/1", sel_turn, sel_guess, sel_black, sel_white); end
  endtask

  task automatic test_empty_browse();
    reset = 1'b1;
    tick();
    reset = 1'b0; mode = 1'b1;
    pulse(1'b1, 1'b0, 3'd0, 12'h000);
    pulse(1'b0, 1'b1, 3'd0, 12'h000);
    n_checks++; if ({sel_black, sel_white, empty} !== 7'b0000001) begin n_fail++;
      $display("FAIL empty_browse: got b=%0d w=%0d empty=%b want 0/0/1", sel_black, sel_white, empty); end
    mode = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_store();
    do_store(12'h111, 3'd1, 3'd0, 4'd1);
    do_store(12'h222, 3'd2, 3'd0, 4'd2);
    do_store(12'h333, 3'd3, 3'd0, 4'd3);
    do_store(12'h444, 3'd0, 3'd4, 4'd4);
    do_store(12'h555, 3'd1, 3'd1, 4'd5);
    guess = 12'h666; fb_black = 3'd2; fb_white = 3'd2;
    btn_select = 1'b1; reset = 1'b1;
    tick();
    btn_select = 1'b0; reset = 1'b0;
    n_checks++; if ({turn_count, store_ack, empty} !== {4'd0, 1'b0, 1'b1}) begin n_fail++;
      $display("FAIL reset_store: got cnt=%0d ack=%b empty=%b want 0/0/1", turn_count, store_ack, empty); end
    tick();
    n_checks++; if ({store_ack, sel_turn, sel_guess, sel_black, sel_white} !== 22'd0) begin n_fail++;
      $display("FAIL reset_store_outputs: got ack=%b turn=%0d %h/%0d/%0d want all 0", store_ack, sel_turn, sel_guess, sel_black, sel_white); end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
    guess = '0; fb_black = '0; fb_white = '0;
    test_reset();
    test_store();
    test_browse();
    test_full();
    test_empty_browse();
    test_reset_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/guess_history_buf.md
Name: guess_history_buf

Overview:
Parametrised turn-history store for the Mastermind game datapath. Records each committed guess with its feedback score (black/white peg counts) in a DEPTH-entry buffer. Lets the player browse past turns with up/down buttons in history mode. In guess mode it always presents the most recent turn to the display and feedback logic.

Parameters:
NUM_PEGS, 4, pegs per guess
PEG_W, 3, bits per peg colour
DEPTH, 8, maximum stored turns (power of two not required, >=2)
TURN_W, $clog2(DEPTH), width of turn indices
CNT_W, $clog2(NUM_PEGS+1), width of each feedback count

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; clock clk
mode  in  1  0 = guess mode, 1 = history/browse mode
btn_up  in  1  single-cycle debounced pulse, browse to newer turn
btn_down  in  1  single-cycle debounced pulse, browse to older turn
btn_select  in  1  single-cycle pulse, commit current guess
guess  in  NUM_PEGS*PEG_W  current guess; peg i at [i*PEG_W +: PEG_W]
fb_black  in  CNT_W  black count for guess, valid with btn_select
fb_white  in  CNT_W  white count for guess, valid with btn_select
sel_guess  out  NUM_PEGS*PEG_W  guess of displayed turn
sel_black  out  CNT_W  black count of displayed turn
sel_white  out  CNT_W  white count of displayed turn
sel_turn  out  TURN_W  index of displayed turn
turn_count  out  TURN_W+1  number of stored turns, 0..DEPTH
empty  out  1  turn_count == 0
full  out  1  turn_count == DEPTH (last turn used)
store_ack  out  1  one-cycle pulse: guess accepted
overflow  out  1  one-cycle pulse: select while full, discarded

Behaviour:
- Reset: turn_count=0, sel_turn=0, all sel_* outputs 0, empty=1, full=0, store_ack=0, overflow=0. Memory contents are don't-care; reads are masked by empty.
- Store: cycle N, mode=0, btn_select=1, !full -> write {guess, fb_black, fb_white} at index turn_count. turn_count++ and store_ack=1 in cycle N+1. sel_turn=old turn_count at N+1. sel_guess/sel_black/sel_white show the new entry at N+2 (one-cycle registered read).
- Store while full -> no write, counts unchanged, overflow=1 for one cycle.
- btn_select is ignored in mode=1.
- Guess mode with no store: sel_turn holds turn_count-1 (0 if empty).
- Browse (mode=1, !empty):
  - btn_up with sel_turn < turn_count-1 -> sel_turn++.
  - btn_down with sel_turn > 0 -> sel_turn--.
  - At either limit the button is ignored (no wrap).
  - btn_up and btn_down in the same cycle -> no change.
- Browse when empty: buttons ignored, all sel_* outputs 0.
- Mode change 1->0: sel_turn snaps to turn_count-1 on the next cycle.
- Mode change 0->1: sel_turn keeps its value, which is the latest turn.
- Read path: sel_* are registered from mem[sel_turn]. Latency is 1 cycle after any sel_turn change. Outputs are forced to 0 when empty.
- Write and read of the same index in the same cycle -> the read returns the new data (write-first bypass).
- Reset mid-store: reset wins; no write, turn_count=0.
- full is combinational from turn_count. store_ack and overflow are registered.

Decomposition:
- Package mm_pkg: NUM_PEGS, PEG_W, CNT_W defaults; typedef peg_t, guess_t, and a fb_t struct {black, white}; entry_t = {guess_t, fb_t}.
- Sub-module history_ram: DEPTH x $bits(entry_t), one synchronous write port, one registered read port with write-first bypass.
- Top-level holds the counters, browse control and output masking.

Test Plan:
- Reset then 3 stores (guess 0x123/b1w2, 0x456/b0w0, 0x777/b4w0) -> turn_count=3; sel_turn=2; sel_guess=0x777, sel_black=4 two cycles after the last select; store_ack pulses 3 times.
- After that, mode=1, btn_down x3 -> sel_turn 2,1,0,0; sel_guess 0x777,0x456,0x123,0x123. Then btn_up x3 -> sel_turn 1,2,2.
- Store 8 guesses -> full=1. A 9th select -> overflow=1 for one cycle; turn_count stays 8; entry 7 unchanged.
- mode=1 while empty, btn_up/btn_down pulses -> sel_turn=0, sel_* all 0, empty=1.
- Simultaneous btn_up+btn_down at sel_turn=1 -> sel_turn stays 1. Mode 1->0 -> sel_turn = turn_count-1 next cycle.
- Reset asserted in the same cycle as btn_select at turn_count=5 -> turn_count=0, no store_ack, sel_* 0.
